// File: rtl/lcd_timing_rx.sv
// rtl/lcd_timing_rx.sv - DE-only LCD timing receiver with format measurement and lock
module lcd_timing_rx #(
  parameter int EXP_H_DISP  = 800,
  parameter int EXP_V_DISP  = 480,
  parameter int VBLANK_MIN  = 1500,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vid_de,
  input  logic [23:0] vid_rgb,
  output logic        pix_valid,
  output logic [23:0] pix_data,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        sof,
  output logic        eol,
  output logic        eof,
  output logic [11:0] meas_h_disp,
  output logic [11:0] meas_h_total,
  output logic [11:0] meas_v_disp,
  output logic        locked,
  output logic        fmt_err
);

  localparam logic [12:0] H_EXP    = 13'(EXP_H_DISP);
  localparam logic [11:0] V_EXP    = 12'(EXP_V_DISP);
  localparam logic [15:0] GAP_END  = 16'(VBLANK_MIN - 1);
  localparam logic [3:0]  LOCK_N   = 4'(LOCK_FRAMES);
  localparam logic [12:0] RUN_SAT  = 13'd4096;
  localparam logic [11:0] CNT_MAX  = 12'hFFF;

  typedef enum logic [1:0] {SEARCH, LOCKING, LOCKED} state_t;

  state_t      state, state_n;
  logic [3:0]  good_cnt, good_cnt_n;
  logic        armed, in_line, in_frame, primed, frame_bad;
  logic [12:0] run_cnt;
  logic [11:0] tot_cnt, line_cnt;
  logic [15:0] gap_cnt;
  logic        rise, frame_start, fall, run_long, h_bad, eof_det, v_bad, good_eof;

  // Edge and event decode; pix_valid doubles as the delayed DE for edge detection.
  // in_line is set only for armed lines, so a DE run already high at reset release is ignored.
  assign rise        = vid_de & ~pix_valid & armed;
  assign frame_start = rise & ~in_frame;
  assign fall        = ~vid_de & in_line;
  assign run_long    = vid_de & in_line & (run_cnt == 13'd4095);
  assign h_bad       = fall & (run_cnt != H_EXP) & (run_cnt != RUN_SAT);
  assign eof_det     = ~vid_de & in_frame & (gap_cnt == GAP_END);
  assign v_bad       = eof_det & (line_cnt != V_EXP);
  assign eol         = fall;
  assign locked      = (state == LOCKED);

  // Pixel pipeline, line tracking and coordinates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
      armed     <= 1'b0;
      in_line   <= 1'b0;
      run_cnt   <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      line_cnt  <= '0;
      sof       <= 1'b0;
    end else begin
      pix_valid <= vid_de;
      pix_data  <= vid_de ? vid_rgb : 24'h0;
      armed     <= armed | ~vid_de;
      in_line   <= rise | (vid_de & in_line);
      sof       <= frame_start;
      if (rise)
        run_cnt <= 13'd1;
      else if (vid_de && in_line && run_cnt != RUN_SAT)
        run_cnt <= run_cnt + 13'd1;
      if (rise)
        pix_x <= '0;
      else if (vid_de && in_line && pix_x != CNT_MAX)
        pix_x <= pix_x + 12'd1;
      if (frame_start) begin
        pix_y    <= '0;
        line_cnt <= 12'd1;
      end else if (rise) begin
        if (pix_y != CNT_MAX) pix_y <= pix_y + 12'd1;
        if (line_cnt != CNT_MAX) line_cnt <= line_cnt + 12'd1;
      end
    end
  end

  // Horizontal measurements: DE-high run length and rise-to-rise period within a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tot_cnt      <= '0;
      meas_h_disp  <= '0;
      meas_h_total <= '0;
    end else begin
      if (rise)
        tot_cnt <= 12'd1;
      else if (tot_cnt != CNT_MAX)
        tot_cnt <= tot_cnt + 12'd1;
      if (rise && in_frame)
        meas_h_total <= tot_cnt;
      if (fall)
        meas_h_disp <= run_cnt[12] ? CNT_MAX : run_cnt[11:0];
    end
  end

  // Vertical blanking detection, frame bracketing and error pulse generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt     <= '0;
      in_frame    <= 1'b0;
      eof         <= 1'b0;
      meas_v_disp <= '0;
      fmt_err     <= 1'b0;
      primed      <= 1'b0;
      frame_bad   <= 1'b0;
    end else begin
      if (vid_de)
        gap_cnt <= '0;
      else if (gap_cnt != 16'hFFFF)
        gap_cnt <= gap_cnt + 16'd1;
      if (frame_start)
        in_frame <= 1'b1;
      else if (eof_det)
        in_frame <= 1'b0;
      eof     <= eof_det;
      fmt_err <= h_bad | v_bad | run_long;
      if (eof_det)
        meas_v_disp <= line_cnt;
      // The first frame after reset may be partial, so its eof only primes the lock logic.
      if (eof)
        primed <= 1'b1;
      if (eof)
        frame_bad <= 1'b0;
      else if (fmt_err)
        frame_bad <= 1'b1;
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_n;
      good_cnt <= good_cnt_n;
    end
  end

  // Lock FSM next state: count consecutive error-free frames, drop on any error.
  always_comb begin
    state_n    = state;
    good_cnt_n = good_cnt;
    good_eof   = eof & primed & ~frame_bad & ~fmt_err;
    if (fmt_err) begin
      state_n    = SEARCH;
      good_cnt_n = '0;
    end else if (good_eof) begin
      case (state)
        SEARCH: begin
          good_cnt_n = 4'd1;
          state_n    = (LOCK_N == 4'd1) ? LOCKED : LOCKING;
        end
        LOCKING: begin
          good_cnt_n = good_cnt + 4'd1;
          if (good_cnt + 4'd1 >= LOCK_N) state_n = LOCKED;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_timing_rx.sv
// tb/tb_lcd_timing_rx.sv - directed self-checking bench for lcd_timing_rx
module tb_lcd_timing_rx;

  logic        clk, rst_n, vid_de;
  logic [23:0] vid_rgb;
  logic        pix_valid, sof, eol, eof, locked, fmt_err;
  logic [23:0] pix_data;
  logic [11:0] pix_x, pix_y, meas_h_disp, meas_h_total, meas_v_disp;

  int checks = 0;
  int errors = 0;

  int step_no, last_rise_step, sof_lat, eol_step, eof_step, err_step, err_eol_step, unlock_step;
  int n_sof, n_eol, n_eof, n_err;
  logic [11:0] sof_x, sof_y, eol_x, eol_y, err_meas_h;
  logic [23:0] sof_data;
  logic        prev_de, prev_locked;

  lcd_timing_rx #(
    .EXP_H_DISP(8), .EXP_V_DISP(4), .VBLANK_MIN(20), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vid_de(vid_de), .vid_rgb(vid_rgb),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .sof(sof), .eol(eol), .eof(eof), .meas_h_disp(meas_h_disp),
    .meas_h_total(meas_h_total), .meas_v_disp(meas_v_disp),
    .locked(locked), .fmt_err(fmt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_rec();
    n_sof = 0; n_eol = 0; n_eof = 0; n_err = 0;
    err_step = -1; unlock_step = -1; eol_step = -1; eof_step = -1;
    prev_locked = locked;
  endtask

  // Drive one input cycle at the falling edge, then record output events 1 ns later.
  task automatic step(input logic de, input logic [23:0] rgb);
    @(negedge clk);
    vid_de = de;
    vid_rgb = rgb;
    step_no++;
    if (de && !prev_de) last_rise_step = step_no;
    prev_de = de;
    #1;
    if (sof) begin
      n_sof++; sof_lat = step_no - last_rise_step;
      sof_x = pix_x; sof_y = pix_y; sof_data = pix_data;
    end
    if (eol) begin n_eol++; eol_step = step_no; eol_x = pix_x; eol_y = pix_y; end
    if (eof) begin n_eof++; eof_step = step_no; end
    if (fmt_err) begin
      n_err++;
      if (err_step < 0) begin err_step = step_no; err_eol_step = eol_step; err_meas_h = meas_h_disp; end
    end
    if (prev_locked && !locked && unlock_step < 0) unlock_step = step_no;
    prev_locked = locked;
  endtask

  task automatic send_line(input int len, input int low, input logic [7:0] tag);
    for (int i = 0; i < len; i++) step(1'b1, {tag, 16'(i)});
    for (int i = 0; i < low; i++) step(1'b0, 24'h0);
  endtask

  task automatic send_frame(input logic [7:0] tag, input int short_line);
    for (int l = 0; l < 4; l++)
      send_line((l == short_line) ? 7 : 8, (l == 3) ? 30 : 4, tag);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vid_de = 1'b0; vid_rgb = 24'h0; prev_de = 1'b0; step_no = 0;
    last_rise_step = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({pix_valid, sof, eol, eof, locked, fmt_err} !== 6'b0) begin errors++; $display("FAIL reset_flags got %b exp 000000", {pix_valid, sof, eol, eof, locked, fmt_err}); end
    checks++; if (pix_data !== 24'h0) begin errors++; $display("FAIL reset_data got %h exp 0", pix_data); end
    checks++; if ({pix_x, pix_y} !== 24'h0) begin errors++; $display("FAIL reset_xy got %0d,%0d exp 0,0", pix_x, pix_y); end
    checks++; if ({meas_h_disp, meas_h_total, meas_v_disp} !== 36'h0) begin errors++; $display("FAIL reset_meas got %0d %0d %0d exp 0 0 0", meas_h_disp, meas_h_total, meas_v_disp); end
    rst_n = 1'b1;
    clear_rec();
    repeat (5) step(1'b0, 24'h0);
  endtask

  task automatic test_nominal();
    clear_rec();
    send_frame(8'h11, -1);
    checks++; if (n_sof !== 1) begin errors++; $display("FAIL nom_sof_count got %0d exp 1", n_sof); end
    checks++; if ({sof_x, sof_y} !== 24'h0) begin errors++; $display("FAIL nom_sof_xy got %0d,%0d exp 0,0", sof_x, sof_y); end
    checks++; if (sof_data !== 24'h110000) begin errors++; $display("FAIL nom_sof_data got %h exp 110000", sof_data); end
    checks++; if (sof_lat !== 1) begin errors++; $display("FAIL nom_latency got %0d exp 1", sof_lat); end
    checks++; if (eol_x !== 12'd7 || eol_y !== 12'd3) begin errors++; $display("FAIL nom_last_xy got %0d,%0d exp 7,3", eol_x, eol_y); end
    checks++; if (n_eol !== 4) begin errors++; $display("FAIL nom_eol_count got %0d exp 4", n_eol); end
    checks++; if (n_eof !== 1) begin errors++; $display("FAIL nom_eof_count got %0d exp 1", n_eof); end
    checks++; if (meas_h_disp !== 12'd8) begin errors++; $display("FAIL nom_h_disp got %0d exp 8", meas_h_disp); end
    checks++; if (meas_h_total !== 12'd12) begin errors++; $display("FAIL nom_h_total got %0d exp 12", meas_h_total); end
    checks++; if (meas_v_disp !== 12'd4) begin errors++; $display("FAIL nom_v_disp got %0d exp 4", meas_v_disp); end
    checks++; if (pix_valid !== 1'b0 || pix_data !== 24'h0) begin errors++; $display("FAIL nom_blank_data got %b/%h exp 0/0", pix_valid, pix_data); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL nom_lock_f1 got %b exp 0", locked); end
    send_frame(8'h12, -1);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL nom_lock_f2 got %b exp 0", locked); end
    send_frame(8'h13, -1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL nom_lock_f3 got %b exp 1", locked); end
    checks++; if (n_err !== 0 || n_eof !== 3) begin errors++; $display("FAIL nom_events got err %0d eof %0d exp 0 3", n_err, n_eof); end
  endtask

  task automatic test_fmt_err();
    clear_rec();
    send_frame(8'h22, 1);
    checks++; if (n_err !== 1) begin errors++; $display("FAIL err_count got %0d exp 1", n_err); end
    checks++; if (err_step - err_eol_step !== 1) begin errors++; $display("FAIL err_delay got %0d exp 1", err_step - err_eol_step); end
    checks++; if (unlock_step - err_step !== 1) begin errors++; $display("FAIL err_unlock_delay got %0d exp 1", unlock_step - err_step); end
    checks++; if (err_meas_h !== 12'd7) begin errors++; $display("FAIL err_h_disp got %0d exp 7", err_meas_h); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL err_lock_bad got %b exp 0", locked); end
    send_frame(8'h23, -1);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL err_lock_g1 got %b exp 0", locked); end
    send_frame(8'h24, -1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL err_relock got %b exp 1", locked); end
  endtask

  task automatic test_vcount();
    clear_rec();
    send_line(8, 4, 8'h31);
    send_line(8, 4, 8'h31);
    send_line(8, 30, 8'h31);
    checks++; if (meas_v_disp !== 12'd3) begin errors++; $display("FAIL vc_v_disp got %0d exp 3", meas_v_disp); end
    checks++; if (n_err !== 1 || err_step !== eof_step) begin errors++; $display("FAIL vc_err got count %0d step %0d exp count 1 step %0d", n_err, err_step, eof_step); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL vc_lock got %b exp 0", locked); end
  endtask

  task automatic test_blank_boundary();
    clear_rec();
    for (int l = 0; l < 3; l++) send_line(8, 19, 8'h41);
    checks++; if (n_eof !== 0) begin errors++; $display("FAIL bb_short_gap_eof got %0d exp 0", n_eof); end
    checks++; if (meas_h_total !== 12'd27) begin errors++; $display("FAIL bb_h_total got %0d exp 27", meas_h_total); end
    send_line(8, 20, 8'h41);
    repeat (10) step(1'b0, 24'h0);
    checks++; if (n_eof !== 1) begin errors++; $display("FAIL bb_eof_count got %0d exp 1", n_eof); end
    checks++; if (eol_y !== 12'd3 || meas_v_disp !== 12'd4) begin errors++; $display("FAIL bb_lines got y %0d v %0d exp 3 4", eol_y, meas_v_disp); end
    send_line(8, 4, 8'h42);
    checks++; if (n_sof !== 2 || sof_y !== 12'd0) begin errors++; $display("FAIL bb_new_frame got sof %0d y %0d exp 2 0", n_sof, sof_y); end
    checks++; if (meas_h_total !== 12'd27) begin errors++; $display("FAIL bb_h_total_hold got %0d exp 27", meas_h_total); end
  endtask

  task automatic test_long_de();
    clear_rec();
    send_line(4100, 10, 8'h51);
    checks++; if (n_err !== 1) begin errors++; $display("FAIL long_err_count got %0d exp 1", n_err); end
    checks++; if (err_step - last_rise_step !== 4096) begin errors++; $display("FAIL long_err_pos got %0d exp 4096", err_step - last_rise_step); end
    checks++; if (eol_x !== 12'd4095) begin errors++; $display("FAIL long_x_sat got %0d exp 4095", eol_x); end
    checks++; if (meas_h_disp !== 12'd4095) begin errors++; $display("FAIL long_h_disp got %0d exp 4095", meas_h_disp); end
  endtask

  task automatic test_reset_midline();
    repeat (3) step(1'b1, 24'hABCDEF);
    rst_n = 1'b0;
    #1;
    checks++; if (pix_valid !== 1'b0 || pix_data !== 24'h0) begin errors++; $display("FAIL rm_async_data got %b/%h exp 0/0", pix_valid, pix_data); end
    checks++; if ({pix_x, pix_y, meas_h_disp} !== 36'h0) begin errors++; $display("FAIL rm_async_cnt got %0d %0d %0d exp 0 0 0", pix_x, pix_y, meas_h_disp); end
    repeat (3) step(1'b1, 24'hABCDEF);
    rst_n = 1'b1;
    clear_rec();
    repeat (5) step(1'b1, 24'hABCDEF);
    repeat (4) step(1'b0, 24'h0);
    checks++; if (n_sof !== 0 || n_eol !== 0 || n_eof !== 0) begin errors++; $display("FAIL rm_ignored got sof %0d eol %0d eof %0d exp 0 0 0", n_sof, n_eol, n_eof); end
    send_line(8, 4, 8'h61);
    checks++; if (n_sof !== 1 || sof_y !== 12'd0) begin errors++; $display("FAIL rm_restart got sof %0d y %0d exp 1 0", n_sof, sof_y); end
    for (int l = 1; l < 4; l++) send_line(8, (l == 3) ? 30 : 4, 8'h61);
    send_frame(8'h62, -1);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rm_first_discard got %b exp 0", locked); end
    send_frame(8'h63, -1);
    checks++; if (locked !== 1'b1 || n_eof !== 3) begin errors++; $display("FAIL rm_relock got lock %b eof %0d exp 1 3", locked, n_eof); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_fmt_err();
    test_vcount();
    test_blank_boundary();
    test_long_de();
    test_reset_midline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_timing_rx.md
LCD_TIMING_RX -- requirements
Module: lcd_timing_rx

Interface
REQ-001 SHALL have parameter EXP_H_DISP, default 800: expected active pixels per line.
REQ-002 SHALL have parameter EXP_V_DISP, default 480: expected active lines per frame.
REQ-003 SHALL have parameter VBLANK_MIN, default 1500: DE-low run length, in clocks, that marks vertical blanking (range 2..65535).
REQ-004 SHALL have parameter LOCK_FRAMES, default 2: consecutive good frames required to lock (range 1..15).
REQ-005 SHALL have ports, in this order:
- clk  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- vid_de  in  1  incoming display enable
- vid_rgb  in  24  incoming pixel data
- pix_valid  out  1  registered copy of vid_de
- pix_data  out  24  registered pixel data
- pix_x  out  12  column of current pixel
- pix_y  out  12  row of current pixel
- sof  out  1  one-cycle pulse with the first pixel of a frame
- eol  out  1  one-cycle pulse with the last pixel of a line
- eof  out  1  one-cycle pulse at frame-end detection
- meas_h_disp  out  12  last completed line's DE-high length
- meas_h_total  out  12  last rising-edge-to-rising-edge DE period
- meas_v_disp  out  12  active lines in last completed frame
- locked  out  1  format lock
- fmt_err  out  1  one-cycle pulse on format mismatch

Function
REQ-006 SHALL derive all timing from vid_de alone; HS/VS are not inputs (sync widths may be zero).
REQ-007 SHALL register vid_de/vid_rgb into pix_valid/pix_data with exactly 1 clock latency; pix_data SHALL be 0 whenever pix_valid is 0.
REQ-008 SHALL keep a saturating 16-bit DE-low gap counter: cleared while vid_de=1, incremented while vid_de=0, saturating at 65535.
REQ-009 SHALL declare frame end (eof pulse, 1 cycle) on the clock where the gap counter reaches VBLANK_MIN while in-frame; one eof per frame, and none if no line has been seen since the previous eof.
REQ-010 SHALL treat the first DE rising edge after eof (or after reset) as frame start: pix_y=0, pix_x=0, sof=1 on that pixel's output cycle.
REQ-011 pix_x SHALL increment by 1 per valid pixel, saturate at 4095, and reset to 0 on each DE rising edge.
REQ-012 pix_y SHALL increment by 1 on each DE rising edge other than frame start, saturate at 4095.
REQ-013 eol SHALL assert with the output pixel whose following input vid_de is 0, i.e. the last DE-high cycle of a line; a single-pixel line gives sof/eol on the same cycle.
REQ-014 On each DE falling edge, meas_h_disp SHALL load the completed run length (saturated at 4095).
REQ-015 meas_h_total SHALL load cycles between successive DE rising edges within one frame (saturated at 4095); not updated across a frame boundary.
REQ-016 On eof, meas_v_disp SHALL load the frame's line count.
REQ-017 fmt_err SHALL pulse 1 cycle after a DE falling edge whose run length != EXP_H_DISP, and on eof when line count != EXP_V_DISP; both in same cycle produce a single pulse.
REQ-018 SHALL implement FSM SEARCH -> LOCKING -> LOCKED:
- SEARCH: on eof of an error-free frame go LOCKING with good count 1 (if LOCK_FRAMES=1 go LOCKED directly).
- LOCKING: each error-free eof increments count; reaching LOCK_FRAMES -> LOCKED.
- any state: fmt_err -> SEARCH, count 0.
- locked=1 only in LOCKED.
REQ-019 A frame during which reset deasserted mid-line SHALL not count as good: first eof after reset never advances the FSM.
REQ-020 DE high continuously for >4095 cycles SHALL pulse fmt_err once (at run length 4096) and hold pix_x at 4095.

Reset
REQ-021 On rst_n low, all outputs SHALL be 0 asynchronously, FSM=SEARCH, all counters 0, gap counter 0 and in-frame flag clear.
REQ-022 After rst_n rises, the block SHALL ignore vid_de until its first 0->1 transition (DE high at release is not a frame start).

Verification
REQ-023 Nominal: 3 frames of 800 DE-high/392 DE-low lines, 480 lines, 45*1192 blank -> meas_h_disp=800, meas_h_total=1192, meas_v_disp=480, locked=1 after 3rd eof (1st discarded per REQ-019).
REQ-024 Coordinates: first pixel of frame -> pix_x=0, pix_y=0, sof=1; last pixel -> pix_x=799, pix_y=479, eol=1; latency 1 clock.
REQ-025 Error: in a locked stream, one line of 799 pixels -> fmt_err pulse 1 cycle after its falling edge, locked=0 next cycle, relock after 2 good frames.
REQ-026 Blank boundary: DE-low gap of VBLANK_MIN-1 -> no eof, pix_y continues; gap of VBLANK_MIN -> exactly one eof.
REQ-027 Reset mid-line with DE high: outputs 0 immediately, no sof until next DE rising edge, pix_y restarts at 0.
